text_writer: RTL and testbench

- Writer side of the greeting text buffer.
- Accepts a byte stream (valid/ready) of ASCII characters and control codes, maps each to a displayable code point (0x20–0x5F), and writes it at a cursor into the write port of the dual-port message RAM.
- The text renderer reads that RAM as GREET_MSGS messages of GREET_LENGTH code points.
- Owns cursor, line-fill and clear sequencing so software/UART can stream text directly.

---
 rtl/text_writer_if.sv | 30 +++
 rtl/text_writer.sv | 173 +++++++++++++++++
 tb/tb_text_writer.sv | 263 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/text_writer_if.sv
`default_nettype none
// ============================================================================
//  Module   : text_writer_if
//  Purpose  : Byte-stream input and RAM write-port bundle for text_writer.
//  Revision : 1.0  initial release
// ============================================================================
interface text_writer_if #(
  parameter int ADDRW    = 9,
  parameter int CP_WIDTH = 7
);
  logic [7:0]          in_data;
  logic                in_valid;
  logic                in_ready;
  logic                wr_en;
  logic [ADDRW-1:0]    wr_addr;
  logic [CP_WIDTH-1:0] wr_data;
  logic [ADDRW-1:0]    cursor;
  logic                busy;

  modport master (
    output in_data, in_valid,
    input  in_ready, wr_en, wr_addr, wr_data, cursor, busy
  );

  modport slave (
    input  in_data, in_valid,
    output in_ready, wr_en, wr_addr, wr_data, cursor, busy
  );
endinterface
`default_nettype wire

// File: rtl/text_writer.sv
`default_nettype none
// ============================================================================
//  Module   : text_writer
//  Purpose  : Maps an ASCII byte stream to code points and writes them at a
//             cursor into the greeting RAM, with newline fill and clear.
//  Revision : 1.0  initial release
// ============================================================================
module text_writer #(
  parameter int GREET_MSGS   = 32,
  parameter int GREET_LENGTH = 16,
  parameter int CP_WIDTH     = 7,
  parameter int ADDRW        = 9
) (
  input  wire logic     video_clk_pix,
  input  wire logic     rst,
  text_writer_if.slave  bus
);

  localparam int                  DEPTH      = GREET_MSGS * GREET_LENGTH;
  localparam int                  COLW       = $clog2(GREET_LENGTH);
  localparam logic [ADDRW-1:0]    LAST_ADDR  = ADDRW'(DEPTH - 1);
  localparam logic [ADDRW-1:0]    COL_MASK   = ADDRW'(GREET_LENGTH - 1);
  localparam logic [CP_WIDTH-1:0] CP_SPACE   = CP_WIDTH'(8'h20);
  localparam logic [7:0]          CH_BS      = 8'h08;
  localparam logic [7:0]          CH_LF      = 8'h0A;
  localparam logic [7:0]          CH_FF      = 8'h0C;
  localparam logic [7:0]          CH_CR      = 8'h0D;

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_FILL  = 2'd1,
    S_CLEAR = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [ADDRW-1:0]    cursor_q, cursor_d;
  logic                wr_en_q, wr_en_d;
  logic [ADDRW-1:0]    wr_addr_q, wr_addr_d;
  logic [CP_WIDTH-1:0] wr_data_q, wr_data_d;

  logic                w_ready;
  logic                w_accept;
  logic [ADDRW-1:0]    w_cursor_inc;
  logic [COLW-1:0]     w_col_cur;
  logic [COLW-1:0]     w_col_inc;

  // Wrap explicitly so a buffer smaller than 2**ADDRW still wraps correctly.
  function automatic logic [ADDRW-1:0] f_inc(input logic [ADDRW-1:0] a);
    return (a == LAST_ADDR) ? '0 : a + ADDRW'(1);
  endfunction

  function automatic logic [CP_WIDTH-1:0] f_map(input logic [7:0] b);
    logic [7:0] m;
    if (b >= 8'h20 && b <= 8'h5F) begin
      m = b;
    end else if (b >= 8'h61 && b <= 8'h7A) begin
      m = b - 8'h20;
    end else begin
      m = 8'h3F;
    end
    return m[CP_WIDTH-1:0];
  endfunction

  assign w_ready      = (state_q == S_IDLE) && !rst;
  assign w_accept     = bus.in_valid && w_ready;
  assign w_cursor_inc = f_inc(cursor_q);
  assign w_col_cur    = cursor_q[COLW-1:0];
  assign w_col_inc    = w_cursor_inc[COLW-1:0];

  always_comb begin
    state_d   = state_q;
    cursor_d  = cursor_q;
    wr_en_d   = 1'b0;
    wr_addr_d = wr_addr_q;
    wr_data_d = wr_data_q;

    case (state_q)
      S_IDLE: begin
        if (w_accept) begin
          case (bus.in_data)
            CH_LF: begin
              if (w_col_cur != '0) begin
                wr_en_d   = 1'b1;
                wr_addr_d = cursor_q;
                wr_data_d = CP_SPACE;
                cursor_d  = w_cursor_inc;
                if (w_col_inc != '0) begin
                  state_d = S_FILL;
                end
              end
            end
            CH_FF: begin
              // The first clear write happens in the accept cycle itself.
              wr_en_d   = 1'b1;
              wr_addr_d = '0;
              wr_data_d = CP_SPACE;
              cursor_d  = f_inc('0);
              if (f_inc('0) != '0) begin
                state_d = S_CLEAR;
              end
            end
            CH_BS: begin
              if (cursor_q != '0) begin
                wr_en_d   = 1'b1;
                wr_addr_d = cursor_q - ADDRW'(1);
                wr_data_d = CP_SPACE;
                cursor_d  = cursor_q - ADDRW'(1);
              end
            end
            CH_CR: begin
              cursor_d = cursor_q & ~COL_MASK;
            end
            default: begin
              wr_en_d   = 1'b1;
              wr_addr_d = cursor_q;
              wr_data_d = f_map(bus.in_data);
              cursor_d  = w_cursor_inc;
            end
          endcase
        end
      end

      S_FILL: begin
        wr_en_d   = 1'b1;
        wr_addr_d = cursor_q;
        wr_data_d = CP_SPACE;
        cursor_d  = w_cursor_inc;
        if (w_col_inc == '0) begin
          state_d = S_IDLE;
        end
      end

      S_CLEAR: begin
        wr_en_d   = 1'b1;
        wr_addr_d = cursor_q;
        wr_data_d = CP_SPACE;
        cursor_d  = w_cursor_inc;
        if (w_cursor_inc == '0) begin
          state_d = S_IDLE;
        end
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge video_clk_pix or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      cursor_q  <= '0;
      wr_en_q   <= 1'b0;
      wr_addr_q <= '0;
      wr_data_q <= '0;
    end else begin
      state_q   <= state_d;
      cursor_q  <= cursor_d;
      wr_en_q   <= wr_en_d;
      wr_addr_q <= wr_addr_d;
      wr_data_q <= wr_data_d;
    end
  end

  assign bus.in_ready = w_ready;
  assign bus.wr_en    = wr_en_q;
  assign bus.wr_addr  = wr_addr_q;
  assign bus.wr_data  = wr_data_q;
  assign bus.cursor   = cursor_q;
  assign bus.busy     = (state_q != S_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_text_writer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_text_writer
//  Purpose  : Scoreboard bench for text_writer against a byte-level model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_text_writer;

  localparam int DEPTH = 512;
  localparam int LEN   = 16;

  typedef struct {
    int addr;
    int data;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  text_writer_if #(.ADDRW(9), .CP_WIDTH(7)) bus ();

  text_writer #(
    .GREET_MSGS  (32),
    .GREET_LENGTH(16),
    .CP_WIDTH    (7),
    .ADDRW       (9)
  ) dut (
    .video_clk_pix(clk),
    .rst          (rst),
    .bus          (bus)
  );

  int   total  = 0;
  int   passed = 0;
  int   cyc    = 0;
  int   mc     = 0;
  exp_t q[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  function automatic int ref_map(input int b);
    if (b >= 32 && b <= 95) return b;
    if (b >= 97 && b <= 122) return b - 32;
    return 63;
  endfunction

  function automatic void push_wr(input int a, input int d, input int c);
    exp_t e;
    e.addr = a;
    e.data = d;
    e.cyc  = c;
    q.push_back(e);
  endfunction

  // Model of the text buffer: what every accepted byte writes, and when.
  function automatic void model(input int b, input int c);
    int col;
    col = mc % LEN;
    case (b)
      10: if (col != 0) begin
        for (int i = 0; i < LEN - col; i++) begin
          push_wr(mc, 32, c + 1 + i);
          mc = (mc + 1) % DEPTH;
        end
      end
      12: begin
        for (int a = 0; a < DEPTH; a++) push_wr(a, 32, c + 1 + a);
        mc = 0;
      end
      8: if (mc > 0) begin
        mc = mc - 1;
        push_wr(mc, 32, c + 1);
      end
      13: mc = mc - col;
      default: begin
        push_wr(mc, ref_map(b), c + 1);
        mc = (mc + 1) % DEPTH;
      end
    endcase
  endfunction

  always @(negedge clk) begin
    exp_t e;
    cyc++;
    if (!rst && bus.wr_en === 1'b1) begin
      if (q.size() == 0) begin
        chk("unexpected_write", 32'(bus.wr_en), 32'd0);
      end else begin
        e = q.pop_front();
        chk("wr_addr", 32'(bus.wr_addr), e.addr);
        chk("wr_data", 32'(bus.wr_data), e.data);
        chk("wr_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.in_ready !== 1'b1) begin
      n++;
      if (n > 2000) begin
        chk("ready_timeout", 32'(bus.in_ready), 32'd1);
        return;
      end
      @(negedge clk);
    end
    bus.in_data  = b;
    bus.in_valid = 1'b1;
    @(posedge clk);
    model(int'(b), cyc);
    #1 bus.in_valid = 1'b0;
  endtask

  task automatic check_cursor(input string name);
    int n;
    n = 0;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && n < 2000) begin
      n++;
      @(negedge clk);
    end
    chk(name, 32'(bus.cursor), mc);
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 2000) begin
      n++;
      @(negedge clk);
    end
    chk("queue_drain", q.size(), 32'd0);
  endtask

  initial begin
    int cnt;
    int r;
    logic [7:0] b;

    bus.in_valid = 1'b0;
    bus.in_data  = 8'h00;

    repeat (3) @(negedge clk);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd0);
    chk("rst_wr_en",    32'(bus.wr_en),    32'd0);
    chk("rst_cursor",   32'(bus.cursor),   32'd0);
    chk("rst_busy",     32'(bus.busy),     32'd0);
    chk("rst_wr_addr",  32'(bus.wr_addr),  32'd0);
    chk("rst_wr_data",  32'(bus.wr_data),  32'd0);
    rst = 1'b0;

    // "hi!" streamed back to back
    send(8'h68); chk("ready_after_h", 32'(bus.in_ready), 32'd1);
    send(8'h69); chk("ready_after_i", 32'(bus.in_ready), 32'd1);
    send(8'h21); chk("ready_after_bang", 32'(bus.in_ready), 32'd1);
    check_cursor("cursor_hi");
    chk("cursor_hi_const", 32'(bus.cursor), 32'd3);

    // newline from column 3
    send(8'h0A);
    cnt = 0;
    @(negedge clk);
    while (bus.in_ready !== 1'b1 && cnt < 100) begin
      cnt++;
      @(negedge clk);
    end
    chk("lf_ready_low_cycles", cnt, 32'd12);
    wait_drain();
    chk("cursor_after_lf", 32'(bus.cursor), 32'd16);
    send(8'h0A);
    repeat (3) @(negedge clk);
    chk("cursor_lf_col0", 32'(bus.cursor), 32'd16);

    // clear from cursor 100
    for (int i = 0; i < 5; i++) begin
      send(8'h78);
      send(8'h0A);
    end
    for (int i = 0; i < 4; i++) send(8'h78);
    check_cursor("cursor_100");
    send(8'h0C);
    cnt = 0;
    @(negedge clk);
    while (bus.busy === 1'b1 && cnt < 600) begin
      cnt++;
      @(negedge clk);
    end
    chk("ff_busy_cycles", cnt, 32'd511);
    chk("ff_ready_at_n512", 32'(bus.in_ready), 32'd1);
    wait_drain();
    chk("cursor_after_ff", 32'(bus.cursor), 32'd0);

    // wrap at the end of the buffer
    for (int i = 0; i < 31; i++) begin
      send(8'h78);
      send(8'h0A);
    end
    for (int i = 0; i < 15; i++) send(8'h78);
    check_cursor("cursor_511");
    send(8'h41);
    check_cursor("cursor_wrap");
    send(8'h08);
    repeat (3) @(negedge clk);
    chk("bs_at_zero_cursor", 32'(bus.cursor), 32'd0);
    send(8'h42);
    send(8'h08);
    check_cursor("cursor_after_bs");

    // unmapped bytes and lowercase
    send(8'h7B); send(8'h01); send(8'hC3); send(8'h60); send(8'h7A);
    check_cursor("cursor_after_map");
    send(8'h0D);
    check_cursor("cursor_after_cr");

    // reset during FILL
    send(8'h61);
    send(8'h62);
    send(8'h0A);
    repeat (5) @(negedge clk);
    #2;
    rst = 1'b1;
    q.delete();
    mc = 0;
    #1;
    chk("rstfill_wr_en",    32'(bus.wr_en),    32'd0);
    chk("rstfill_cursor",   32'(bus.cursor),   32'd0);
    chk("rstfill_busy",     32'(bus.busy),     32'd0);
    chk("rstfill_in_ready", 32'(bus.in_ready), 32'd0);
    @(negedge clk);
    #2 rst = 1'b0;
    #1 chk("rstfill_ready_after", 32'(bus.in_ready), 32'd1);
    repeat (4) @(negedge clk);

    // randomized traffic
    for (int i = 0; i < 300; i++) begin
      r = $urandom_range(0, 99);
      if (r < 6)       b = 8'h0A;
      else if (r < 10) b = 8'h08;
      else if (r < 12) b = 8'h0D;
      else if (r == 12) b = 8'h0C;
      else if (r < 50) b = 8'($urandom_range(8'h61, 8'h7A));
      else             b = 8'($urandom_range(0, 255));
      send(b);
      if (i % 25 == 24) check_cursor("rand_cursor");
    end
    wait_drain();
    check_cursor("final_cursor");
    repeat (3) @(negedge clk);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
`default_nettype wire
